// File: rtl/fpu_pkg.sv
// fpu_pkg: types and defaults shared by the FPU, its decoder and fpu_issue_ctrl.
//   fpuop_t : 4-bit FPU operation encoding (FADD=0 .. FCVTSW=12, 13..15 undefined)
//   state_t : issue sequencer states
//   LAT_*_DEF : default fixed latencies, in cycles, per operation class
package fpu_pkg;

  typedef enum logic [3:0] {
    FADD   = 4'd0,
    FSUB   = 4'd1,
    FMUL   = 4'd2,
    FDIV   = 4'd3,
    FSQRT  = 4'd4,
    FSGNJ  = 4'd5,
    FSGNJN = 4'd6,
    FSGNJX = 4'd7,
    FEQ    = 4'd8,
    FLE    = 4'd9,
    FLT    = 4'd10,
    FCVTWS = 4'd11,
    FCVTSW = 4'd12
  } fpuop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LAT_ADD_DEF  = 2;
  localparam int LAT_MUL_DEF  = 2;
  localparam int LAT_DIV_DEF  = 10;
  localparam int LAT_CVT_DEF  = 2;
  localparam int LAT_MISC_DEF = 1;

endpackage

// File: rtl/fpu_rr_arb2.sv
// fpu_rr_arb2: two-way round-robin arbiter, purely combinational.
//   valid[1:0] in  : request lines
//   last       in  : index of the most recently granted requester
//   en         in  : arbitration allowed this cycle
//   grant[1:0] out : one-hot grant (all zero when !en or no request)
// A lone request always wins; on a tie the requester that did not win last time is chosen.
module fpu_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       en,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) begin
        grant = last ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: shares one fixed-latency combinational FPU between two requesters
// (0: integer pipeline, 1: FP load/convert path), one operation in flight at a time.
//
// Ports
//   clk, rstn                     clock; rstn is a synchronous, active-HIGH reset
//   reqN_valid/ready/op/src0/src1 request channel N (N = 0, 1)
//   fpu_src0/src1/op, fpu_result  FPU operand/op drive and result return
//   out_valid/ready/result/tag    result channel, tag = requester index
//   busy                          an operation is being executed or returned
//   dbg_state                     current sequencer state (state_t encoding)
//   stall0_cnt, stall1_cnt        only with FPU_STALL_CNT_EN: cycles reqN waited
//
// Handshake: a transfer happens on a rising edge where valid && ready. reqN_ready is a
// combinational grant, only offered while idle; the requester must hold op/operands
// until it sees ready. out_valid stays high with result/tag stable until out_ready.
//
// Optional feature macro: FPU_STALL_CNT_EN (wrapping 32-bit stall counters per requester).
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = LAT_ADD_DEF,
  parameter int LAT_MUL  = LAT_MUL_DEF,
  parameter int LAT_DIV  = LAT_DIV_DEF,
  parameter int LAT_CVT  = LAT_CVT_DEF,
  parameter int LAT_MISC = LAT_MISC_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_src0,
  input  logic [31:0] req0_src1,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_src0,
  input  logic [31:0] req1_src1,
  output logic [31:0] fpu_src0,
  output logic [31:0] fpu_src1,
  output logic [3:0]  fpu_op,
  input  logic [31:0] fpu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_tag,
  output logic        busy,
`ifdef FPU_STALL_CNT_EN
  output logic [31:0] stall0_cnt,
  output logic [31:0] stall1_cnt,
`endif
  output logic [1:0]  dbg_state
);

  localparam int LAT_M0  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int LAT_M1  = (LAT_M0 > LAT_DIV) ? LAT_M0 : LAT_DIV;
  localparam int LAT_M2  = (LAT_M1 > LAT_CVT) ? LAT_M1 : LAT_CVT;
  localparam int LAT_MAX = (LAT_M2 > LAT_MISC) ? LAT_M2 : LAT_MISC;
  localparam int CNT_W   = $clog2(LAT_MAX) + 1;

  // Latency minus one: the counter reaches zero on the cycle the result is captured.
  // Anything outside the known classes (including undefined ops) falls back to LAT_MISC.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] op);
    int lat;
    case (op)
      FADD, FSUB:     lat = LAT_ADD;
      FMUL:           lat = LAT_MUL;
      FDIV, FSQRT:    lat = LAT_DIV;
      FCVTWS, FCVTSW: lat = LAT_CVT;
      default:        lat = LAT_MISC;
    endcase
    return CNT_W'(lat - 1);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_last_q, rr_last_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      src0_q, src0_d;
  logic [31:0]      src1_q, src1_d;
  logic             tag_q, tag_d;
  logic [31:0]      result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [1:0]       grant;
  logic [3:0]       sel_op;
  logic [31:0]      sel_src0;
  logic [31:0]      sel_src1;

  fpu_rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .last  (rr_last_q),
    .en    (state_q == IDLE),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign sel_op   = grant[1] ? req1_op   : req0_op;
  assign sel_src0 = grant[1] ? req1_src0 : req0_src0;
  assign sel_src1 = grant[1] ? req1_src1 : req0_src1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_last_d   = rr_last_q;
    op_d        = op_q;
    src0_d      = src0_q;
    src1_d      = src1_q;
    tag_d       = tag_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          op_d      = sel_op;
          src0_d    = sel_src0;
          src1_d    = sel_src1;
          tag_d     = grant[1];
          rr_last_d = grant[1];
          cnt_d     = lat_m1(sel_op);
          busy_d    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // FPU inputs are held in op_q/src*_q for the whole wait.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d    = fpu_result;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

`ifdef FPU_STALL_CNT_EN
  logic [31:0] stall0_cnt_q, stall0_cnt_d;
  logic [31:0] stall1_cnt_q, stall1_cnt_d;

  always_comb begin
    stall0_cnt_d = stall0_cnt_q + {31'd0, req0_valid & ~grant[0]};
    stall1_cnt_d = stall1_cnt_q + {31'd0, req1_valid & ~grant[1]};
  end

  assign stall0_cnt = stall0_cnt_q;
  assign stall1_cnt = stall1_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_last_q   <= 1'b1;  // requester 0 wins the first tie
      op_q        <= '0;
      src0_q      <= '0;
      src1_q      <= '0;
      tag_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FPU_STALL_CNT_EN
      stall0_cnt_q <= '0;
      stall1_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_last_q   <= rr_last_d;
      op_q        <= op_d;
      src0_q      <= src0_d;
      src1_q      <= src1_d;
      tag_q       <= tag_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef FPU_STALL_CNT_EN
      stall0_cnt_q <= stall0_cnt_d;
      stall1_cnt_q <= stall1_cnt_d;
`endif
    end
  end

  assign fpu_op     = op_q;
  assign fpu_src0   = src0_q;
  assign fpu_src1   = src1_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_tag    = tag_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: bench for fpu_issue_ctrl. Contains a stand-in FPU whose result is
// only correct once its inputs have been held for the op's latency, a transaction-level
// reference model checked every cycle, and directed cases with literal expectations.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_src0 = '0, req0_src1 = '0, req1_src0 = '0, req1_src1 = '0;
  logic [31:0] fpu_src0, fpu_src1, fpu_result, out_result;
  logic [3:0]  fpu_op;
  logic        out_valid, out_ready, out_tag, busy;
  logic [1:0]  dbg_state;
`ifdef FPU_STALL_CNT_EN
  logic [31:0] stall0_cnt, stall1_cnt;
`endif

  logic rdy_force = 1'b1;
  logic rand_rdy  = 1'b0;
  logic rnd_bit   = 1'b0;
  assign out_ready = rand_rdy ? rnd_bit : rdy_force;

  initial forever begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  fpu_issue_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_src0  (req0_src0),
    .req0_src1  (req0_src1),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_src0  (req1_src0),
    .req1_src1  (req1_src1),
    .fpu_src0   (fpu_src0),
    .fpu_src1   (fpu_src1),
    .fpu_op     (fpu_op),
    .fpu_result (fpu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy),
`ifdef FPU_STALL_CNT_EN
    .stall0_cnt (stall0_cnt),
    .stall1_cnt (stall1_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- reference rules ----------------
  function automatic int lat_of(input logic [3:0] op);
    if (op == 4'd0 || op == 4'd1) return 2;
    if (op == 4'd2) return 2;
    if (op == 4'd3 || op == 4'd4) return 10;
    if (op == 4'd11 || op == 4'd12) return 2;
    return 1;
  endfunction

  // Stand-in FPU: exact values for the documented cases, distinct mixes elsewhere.
  function automatic logic [31:0] fpu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
      4'd1:  return a - b;
      4'd2:  return a * b;
      4'd3:  return (a == 32'h40C00000 && b == 32'h40000000) ? 32'h40400000 : a ^ {b[15:0], b[31:16]};
      4'd4:  return ~a;
      4'd8:  return {31'd0, a == b};
      4'd9:  return {31'd0, a <= b};
      4'd10: return {31'd0, a < b};
      4'd13, 4'd14, 4'd15: return 32'd0;
      default: return a ^ {b[7:0], b[31:8]} ^ {28'd0, op};
    endcase
  endfunction

  // Result is garbage until inputs have been presented for the full latency.
  logic [31:0] stub_age = '0;
  always @(posedge clk) stub_age <= busy ? stub_age + 32'd1 : 32'd0;
  assign fpu_result = (stub_age >= 32'(lat_of(fpu_op) - 1)) ? fpu_fn(fpu_op, fpu_src0, fpu_src1)
                                                           : (32'hBAD00000 | stub_age);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [31:0] exp_q[$];
  logic        grant_log[$];
  bit          m_have = 0;
  logic        m_tag = 1'b0;
  logic [3:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0;
  int          m_done_at = 0;
  logic        m_last = 1'b1;
  logic [31:0] m_stall0 = '0, m_stall1 = '0;

  // Model: a transaction is either absent or present; when present, its result is due
  // lat+1 cycles after the grant cycle and is retired on the out handshake.
  initial forever begin
    logic e_r0, e_r1, e_ov;
    @(negedge clk);
    if (rstn) begin
      m_have   = 0;
      m_last   = 1'b1;
      m_stall0 = '0;
      m_stall1 = '0;
      exp_q.delete();
    end else begin
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (!m_have) begin
        if (req0_valid && req1_valid) begin
          e_r0 = m_last;
          e_r1 = !m_last;
        end else begin
          e_r0 = req0_valid;
          e_r1 = req1_valid;
        end
      end
      e_ov = m_have && (cyc >= m_done_at);
      chk("req0_ready", 32'(req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(req1_ready), 32'(e_r1));
      chk("busy", 32'(busy), 32'(m_have));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      if (e_ov && exp_q.size() > 0) begin
        chk("out_result", out_result, exp_q[0]);
        chk("out_tag", 32'(out_tag), 32'(m_tag));
      end
      if (m_have) begin
        chk("fpu_op", 32'(fpu_op), 32'(m_op));
        chk("fpu_src0", fpu_src0, m_a);
        chk("fpu_src1", fpu_src1, m_b);
      end
`ifdef FPU_STALL_CNT_EN
      chk("stall0_cnt", stall0_cnt, m_stall0);
      chk("stall1_cnt", stall1_cnt, m_stall1);
`endif
      m_stall0 = m_stall0 + 32'(req0_valid && !e_r0);
      m_stall1 = m_stall1 + 32'(req1_valid && !e_r1);
      if (e_ov && out_ready) begin
        void'(exp_q.pop_front());
        m_have = 0;
      end else if (e_r0 || e_r1) begin
        m_have    = 1;
        m_tag     = e_r1;
        m_op      = e_r1 ? req1_op : req0_op;
        m_a       = e_r1 ? req1_src0 : req0_src0;
        m_b       = e_r1 ? req1_src1 : req0_src1;
        m_done_at = cyc + lat_of(m_op) + 1;
        m_last    = e_r1;
        exp_q.push_back(fpu_fn(m_op, m_a, m_b));
        grant_log.push_back(e_r1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
  endtask

  task automatic set_ready(input logic r, input logic rnd);
    @(posedge clk); #1;
    rdy_force = r;
    rand_rdy  = rnd;
  endtask

  // Present a request until granted or patience runs out; gc = grant cycle or -1.
  task automatic drive_req(input int idx, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int patience, output int gc);
    @(posedge clk); #1;
    if (idx == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_src0 = a; req0_src1 = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_src0 = a; req1_src1 = b;
    end
    gc = -1;
    for (int i = 0; i < patience; i++) begin
      @(negedge clk);
      if ((idx == 0) ? req0_ready : req1_ready) begin
        gc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    if (idx == 0) req0_valid = 1'b0;
    else          req1_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int vc);
    vc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        vc = cyc;
        break;
      end
    end
    if (vc < 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int g, g1, v;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_fpu_op", 32'(fpu_op), 32'd0);
    chk("rst_fpu_src0", fpu_src0, 32'd0);
    chk("rst_fpu_src1", fpu_src1, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // fadd 1.0 + 2.0 on requester 0
    drive_req(0, 4'd0, 32'h3F800000, 32'h40000000, 20, g);
    chk("fadd_granted", 32'(g >= 0), 32'd1);
    wait_valid("fadd", v);
    chk("fadd_latency", 32'(v - g), 32'd3);
    chk("fadd_result", out_result, 32'h40400000);
    chk("fadd_tag", 32'(out_tag), 32'd0);

    // both requesters contending after reset: 0,1,0,1
    pulse_reset();
    grant_log.delete();
    fork
      begin
        drive_req(0, 4'd0, 32'h00000011, 32'h00000022, 50, g);
        drive_req(0, 4'd1, 32'h00000033, 32'h00000004, 50, g);
      end
      begin
        drive_req(1, 4'd2, 32'h00000005, 32'h00000007, 50, g1);
        drive_req(1, 4'd12, 32'h12345678, 32'h0F0F0F0F, 50, g1);
      end
    join
    repeat (6) @(posedge clk);
    chk("rr_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("rr_0", 32'(grant_log[0]), 32'd0);
      chk("rr_1", 32'(grant_log[1]), 32'd1);
      chk("rr_2", 32'(grant_log[2]), 32'd0);
      chk("rr_3", 32'(grant_log[3]), 32'd1);
    end

    // fdiv 6.0/2.0 with the consumer stalled; result held, no new grant
    set_ready(1'b0, 1'b0);
    fork
      begin
        drive_req(0, 4'd3, 32'h40C00000, 32'h40000000, 20, g);
        wait_valid("fdiv", v);
        chk("fdiv_latency", 32'(v - g), 32'd11);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("fdiv_hold_valid", 32'(out_valid), 32'd1);
          chk("fdiv_hold_result", out_result, 32'h40400000);
          chk("fdiv_hold_no_grant", 32'(req1_ready), 32'd0);
        end
        set_ready(1'b1, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        drive_req(1, 4'd0, 32'h00000001, 32'h00000002, 100, g1);
        chk("fdiv_waiter_granted", 32'(g1 >= 0), 32'd1);
      end
    join
    repeat (6) @(posedge clk);

    // feq and an undefined op, both single-cycle latency
    drive_req(0, 4'd8, 32'h3F800000, 32'h3F800000, 20, g);
    wait_valid("feq", v);
    chk("feq_latency", 32'(v - g), 32'd2);
    chk("feq_result", out_result, 32'h00000001);
    drive_req(1, 4'd15, 32'h3F800000, 32'h40000000, 20, g);
    wait_valid("undef", v);
    chk("undef_latency", 32'(v - g), 32'd2);
    chk("undef_result", out_result, 32'h00000000);
    chk("undef_tag", 32'(out_tag), 32'd1);

    // reset while an fsqrt is executing
    drive_req(0, 4'd4, 32'h41100000, 32'h00000000, 20, g);
    repeat (3) @(posedge clk);
    pulse_reset();
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    drive_req(1, 4'd0, 32'h3F800000, 32'h40000000, 20, g);
    chk("midrst_regrant", 32'(g >= 0), 32'd1);
    wait_valid("midrst_next", v);
    chk("midrst_next_latency", 32'(v - g), 32'd3);
    chk("midrst_next_result", out_result, 32'h40400000);

    // requester 1 waiting behind an fdiv from requester 0
    pulse_reset();
    fork
      drive_req(0, 4'd3, 32'h40C00000, 32'h40000000, 20, g);
      drive_req(1, 4'd0, 32'h3F800000, 32'h40000000, 50, g1);
    join
    chk("wait_gap", 32'(g1 - g), 32'd12);
`ifdef FPU_STALL_CNT_EN
    chk("stall1_after_fdiv", stall1_cnt, 32'd12);
    chk("stall0_after_fdiv", stall0_cnt, 32'd0);
`endif
    repeat (6) @(posedge clk);

    // random traffic, random consumer backpressure, requests that give up early
    set_ready(1'b0, 1'b1);
    fork
      for (int n = 0; n < 60; n++) begin
        int gr;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        drive_req(0, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(1, 25), gr);
      end
      for (int n = 0; n < 60; n++) begin
        int gr;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        drive_req(1, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(1, 25), gr);
      end
    join
    set_ready(1'b1, 1'b0);
    repeat (20) @(posedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
